// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, state decode, IR shift/latch.
// Define TAP_IR_EN to build the instruction register; otherwise LATCH_IR is IR_RESET and IR_TDO is 0.
module tap_controller #(
    parameter int                     IR_WIDTH = 4,
    parameter logic [IR_WIDTH-1:0]    IR_RESET = {IR_WIDTH{1'b1}}
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic [3:0]          STATE,
    output logic                TLR,
    output logic                RTI,
    output logic                CAPTURE_DR,
    output logic                SHIFT_DR,
    output logic                UPDATE_DR,
    output logic                CAPTURE_IR,
    output logic                SHIFT_IR,
    output logic                UPDATE_IR,
    output logic [IR_WIDTH-1:0] LATCH_IR,
    output logic                IR_TDO
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_e;

    tap_state_e state_q;

    // NOTE: sequential state is written with <= so every register samples the pre-edge values.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= ST_TLR;
        end else begin
            unique case (state_q)
                ST_TLR:      state_q <= TMS ? ST_TLR    : ST_RTI;
                ST_RTI:      state_q <= TMS ? ST_SEL_DR : ST_RTI;
                ST_SEL_DR:   state_q <= TMS ? ST_SEL_IR : ST_CAP_DR;
                ST_CAP_DR:   state_q <= TMS ? ST_EX1_DR : ST_SH_DR;
                ST_SH_DR:    state_q <= TMS ? ST_EX1_DR : ST_SH_DR;
                ST_EX1_DR:   state_q <= TMS ? ST_UPD_DR : ST_PAUSE_DR;
                ST_PAUSE_DR: state_q <= TMS ? ST_EX2_DR : ST_PAUSE_DR;
                ST_EX2_DR:   state_q <= TMS ? ST_UPD_DR : ST_SH_DR;
                ST_UPD_DR:   state_q <= TMS ? ST_SEL_DR : ST_RTI;
                ST_SEL_IR:   state_q <= TMS ? ST_TLR    : ST_CAP_IR;
                ST_CAP_IR:   state_q <= TMS ? ST_EX1_IR : ST_SH_IR;
                ST_SH_IR:    state_q <= TMS ? ST_EX1_IR : ST_SH_IR;
                ST_EX1_IR:   state_q <= TMS ? ST_UPD_IR : ST_PAUSE_IR;
                ST_PAUSE_IR: state_q <= TMS ? ST_EX2_IR : ST_PAUSE_IR;
                ST_EX2_IR:   state_q <= TMS ? ST_UPD_IR : ST_SH_IR;
                ST_UPD_IR:   state_q <= TMS ? ST_SEL_DR : ST_RTI;
                default:     state_q <= ST_TLR;
            endcase
        end
    end

    // Decode depends on the state register only, never on TMS.
    assign STATE      = state_q;
    assign TLR        = (state_q == ST_TLR);
    assign RTI        = (state_q == ST_RTI);
    assign CAPTURE_DR = (state_q == ST_CAP_DR);
    assign SHIFT_DR   = (state_q == ST_SH_DR);
    assign UPDATE_DR  = (state_q == ST_UPD_DR);
    assign CAPTURE_IR = (state_q == ST_CAP_IR);
    assign SHIFT_IR   = (state_q == ST_SH_IR);
    assign UPDATE_IR  = (state_q == ST_UPD_IR);

`ifdef TAP_IR_EN
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_shift_d;
    logic [IR_WIDTH-1:0] latch_ir_q;
    logic [IR_WIDTH-1:0] latch_ir_d;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ir_shift_d = ir_shift_q;
        latch_ir_d = latch_ir_q;
        unique case (state_q)
            ST_CAP_IR: ir_shift_d = IR_CAPTURE;
            ST_SH_IR:  ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
            ST_UPD_IR: latch_ir_d = ir_shift_q;
            ST_TLR:    latch_ir_d = IR_RESET;
            default: ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_shift_q <= '0;
            latch_ir_q <= IR_RESET;
        end else begin
            ir_shift_q <= ir_shift_d;
            latch_ir_q <= latch_ir_d;
        end
    end

    assign LATCH_IR = latch_ir_q;
    assign IR_TDO   = ir_shift_q[0];
`else
    logic unused_tdi;

    assign unused_tdi = TDI;
    assign LATCH_IR   = IR_RESET;
    assign IR_TDO     = 1'b0;
`endif

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 The block SHALL have the parameter IR_WIDTH, default 4, giving the instruction register width in bits (minimum 2).
REQ-002 The block SHALL have the parameter IR_RESET, default {IR_WIDTH{1'b1}}, giving the instruction loaded in Test-Logic-Reset (all-ones = BYPASS).
REQ-003 TCK  input  1  sole clock; all state changes on posedge TCK.
REQ-004 TRST  input  1  reset, synchronous, active-high, sampled on posedge TCK.
REQ-005 TMS  input  1  test mode select, sampled on posedge TCK.
REQ-006 TDI  input  1  serial data into the IR shift register.
REQ-007 STATE  output  4  current TAP state in IEEE 1149.1 encoding.
REQ-008 TLR, RTI, CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_IR, SHIFT_IR, UPDATE_IR  output  1 each  high while STATE equals the named state.
REQ-009 LATCH_IR  output  IR_WIDTH  active instruction, consumed by the data-register stages.
REQ-010 IR_TDO  output  1  serial IR data out, equal to the IR shift register LSB.

Function
REQ-011 The block SHALL implement the 16-state TAP FSM with the following encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-012 Transitions with TMS=0/1 SHALL be:
- TLR->RTI/TLR; RTI->RTI/SelDR
- SelDR->CapDR/SelIR; CapDR->ShDR/Ex1DR; ShDR->ShDR/Ex1DR
- Ex1DR->PauseDR/UpdDR; PauseDR->PauseDR/Ex2DR; Ex2DR->ShDR/UpdDR
- UpdDR->RTI/SelDR
- SelIR->CapIR/TLR
- IR branch (CapIR, ShIR, Ex1IR, PauseIR, Ex2IR) mirrors the DR branch
- UpdIR->RTI/SelDR
REQ-013 STATE SHALL be a register, and all decode outputs SHALL be combinational from STATE only (no TMS path).
REQ-014 From any state, five consecutive posedges with TMS=1 SHALL reach TLR.
REQ-015 On each posedge where STATE=CapIR, the IR shift register SHALL load {(IR_WIDTH-2){1'b0}},2'b01.
REQ-016 On each posedge where STATE=ShIR, the IR shift register SHALL shift right with TDI into the MSB, regardless of TMS (the exiting edge still shifts).
REQ-017 In all other states the IR shift register SHALL hold its value.
REQ-018 On the posedge where STATE=UpdIR, LATCH_IR SHALL load the IR shift register contents; the new value is visible one cycle later.
REQ-019 On every posedge where STATE=TLR, LATCH_IR SHALL load IR_RESET.
REQ-020 Otherwise LATCH_IR SHALL hold its value, including through all DR-branch states.
REQ-021 IR_TDO SHALL equal the IR shift register bit 0 at all times, with no extra register stage.

Reset
REQ-022 TRST=1 at a posedge SHALL set STATE=TLR, LATCH_IR=IR_RESET and the IR shift register to 0, overriding TMS and any operation in progress.
REQ-023 After reset, the outputs SHALL be TLR=1, all other decode flags 0, and IR_TDO=0.
REQ-024 TRST asserted between posedges SHALL have no effect until the next posedge.

Configuration
REQ-025 When TAP_IR_EN is defined, the IR shift register and the LATCH_IR update logic SHALL be present as specified above.
REQ-026 When TAP_IR_EN is undefined, the IR logic SHALL be omitted:
- LATCH_IR is held constant at IR_RESET
- IR_TDO is constant 0
- the FSM and decode outputs are unchanged

Verification
REQ-027 Bench: TRST=1 for 1 cycle -> STATE=4'hF, TLR=1, LATCH_IR=4'b1111, IR_TDO=0.
REQ-028 Bench: from RTI apply TMS=1,1,1,1,1 -> STATE=4'hF after the 5th edge, with no intermediate UPDATE_IR pulse affecting LATCH_IR before TLR reload.
REQ-029 Bench: from TLR apply TMS=0,1,0,0 -> STATE=4'h2, SHIFT_DR=1; then TMS=1,1 -> UPDATE_DR high for exactly one cycle, then SelDR.
REQ-030 Bench (TAP_IR_EN): IR scan loading 4'b0010 (TDI LSB-first 0,1,0,0, TMS=1 on the 4th bit) -> IR_TDO sequence 1,0,0,0; after UpdIR, LATCH_IR=4'b0010.
REQ-031 Bench: TRST=1 while in ShIR mid-scan (2 of 4 bits shifted) -> next cycle STATE=4'hF and LATCH_IR=IR_RESET; the prior LATCH_IR is not updated.
REQ-032 Bench: PauseIR entered with TMS held 0 for 10 cycles -> STATE stays 4'hB, the IR shift register is unchanged, and IR_TDO is stable.
